dco_trim_ctrl: RTL and testbench
================================

DCO_TRIM_CTRL -- requirements
Module: dco_trim_ctrl

Interface
REQ-001: hiclock  in  1  oscillator-derived clock; all state on its rising edge.
REQ-002: ireset  in  1  reset, asynchronous, active-high.
REQ-003: enable  in  1  loop enable; level, synchronous to hiclock.
REQ-004: osc_ref  in  1  reference clock, asynchronous to hiclock.
REQ-005: target  in  8  required hiclock cycles per osc_ref period; quasi-static.
REQ-006: init_code  in  5  starting trim code loaded on entry to ARM; values >26 clamp to 26.
REQ-007: trim  out  26  thermometer trim word to the ring oscillator, registered.
REQ-008: trim_code  out  5  current trim code, 0..26, registered.
REQ-009: lock  out  1  loop-locked flag, registered.

Function
REQ-010: osc_ref SHALL pass through a 2-flop synchronizer; ref_tick = one-cycle pulse on the synchronized rising edge.
REQ-011: Period counter cnt (8 bit) SHALL load 1 on ref_tick and otherwise increment, saturating at 255; meas = cnt value sampled on ref_tick.
REQ-012: States IDLE, ARM, TRACK; IDLE->ARM when enable=1; ARM->TRACK on first ref_tick (no adjust in ARM); any state->IDLE when enable=0.
REQ-013: On ARM entry, trim_code SHALL load min(init_code,26).
REQ-014: In TRACK, on ref_tick: meas>target -> trim_code+1 (saturate 26); meas<target -> trim_code-1 (saturate 0); equal -> hold.
REQ-015: trim_code and trim SHALL update in the cycle after ref_tick (one-cycle latency), never otherwise in TRACK.
REQ-016: trim SHALL equal (1<<trim_code)-1: bits [12:0] (primary) fill before bits [25:13] (secondary); trim_code=26 -> all ones.
REQ-017: lock SHALL assert after 4 consecutive TRACK ref_ticks with no adjustment (saturating counts included as no adjustment only when clamped); clears on any adjustment, on leaving TRACK.
REQ-018: A ref_tick coinciding with enable falling SHALL be ignored.
REQ-019: In IDLE trim_code/trim SHALL hold last value; lock=0; cnt keeps counting.
REQ-020: A change of target while in TRACK SHALL take effect at the next ref_tick; lock is not cleared by target change alone.

Reset
REQ-021: ireset SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=0, trim_code=0, trim=0, lock=0, lock counter=0.
REQ-022: After ireset deasserts, first ref_tick SHALL require a genuine synchronized rising edge (no spurious tick from reset values).
REQ-023: ireset asserted mid-TRACK SHALL clear outputs immediately, independent of hiclock.

Configuration
REQ-024: Macro DCO_TRIM_DEADBAND_EN: when defined, adjustment SHALL occur only when |meas-target|>1, and |meas-target|<=1 counts as no adjustment for lock; when undefined, REQ-014 exact-compare applies.

Verification
REQ-025: Reset: ireset=1 mid-TRACK with trim_code=9 -> trim=0, trim_code=0, lock=0 same cycle.
REQ-026: target=40, init_code=5, model meas=44 each period -> trim_code 5->6->7 one cycle after each ref_tick, trim=0x7F after second adjust.
REQ-027: Saturation: init_code=31, meas>target -> trim_code=26, trim=0x3FFFFFF, lock asserts after 4 ticks.
REQ-028: Lower bound: init_code=0, meas<target -> trim_code stays 0, trim=0.
REQ-029: Lock: meas==target for 4 ticks -> lock=1; next tick meas=target+2 -> lock=0, trim_code+1; with DCO_TRIM_DEADBAND_EN, meas=target+1 keeps lock=1.
REQ-030: enable dropped on ref_tick cycle -> no adjustment, state IDLE, lock=0, trim held.

Source files
------------

// File: rtl/dco_trim_ctrl.sv
// dco_trim_ctrl: closed-loop ring-oscillator trim that counts hiclock cycles per osc_ref period
// and steps a thermometer trim code toward target. Optional macro: DCO_TRIM_DEADBAND_EN.
module dco_trim_ctrl (
    input  logic        hiclock,
    input  logic        ireset,
    input  logic        enable,
    input  logic        osc_ref,
    input  logic [7:0]  target,
    input  logic [4:0]  init_code,
    output logic [25:0] trim,
    output logic [4:0]  trim_code,
    output logic        lock
);
    typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sync;
    logic [1:0]  fill;
    logic        armed;
    logic        ref_tick;
    logic [7:0]  cnt;
    logic [2:0]  lcnt, lcnt_nxt;
    logic        up, dn, tick_trk, adjust, load;
    logic [4:0]  init_clamp, code_nxt;
    logic [25:0] trim_nxt;

    // Edges only count once the synchronizer holds real samples and has seen osc_ref low,
    // so a reference already high at reset release does not produce a tick.
    always_ff @(posedge hiclock or posedge ireset)
        if (ireset) begin
            sync  <= '0;
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[1:0], osc_ref};
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~sync[1]);
        end

    assign ref_tick = sync[1] & ~sync[2] & armed;

    always_ff @(posedge hiclock or posedge ireset)
        if (ireset)
            cnt <= '0;
        else
            cnt <= ref_tick ? 8'd1 : (cnt == 8'hFF ? cnt : cnt + 8'd1);

    always_ff @(posedge hiclock or posedge ireset)
        if (ireset)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb
        state_nxt = !enable ? IDLE :
                    state == IDLE ? ARM :
                    (state == ARM && ref_tick) ? TRACK : state;

`ifdef DCO_TRIM_DEADBAND_EN
    assign up = {1'b0, cnt} > {1'b0, target} + 9'd1;
    assign dn = {1'b0, cnt} + 9'd1 < {1'b0, target};
`else
    assign up = cnt > target;
    assign dn = cnt < target;
`endif

    // A request that would push the code past its rail is treated as no adjustment.
    always_comb begin
        load       = state == IDLE && enable;
        init_clamp = init_code > 5'd26 ? 5'd26 : init_code;
        tick_trk   = state == TRACK && enable && ref_tick;
        adjust     = tick_trk && ((up && trim_code != 5'd26) || (dn && trim_code != 5'd0));
        code_nxt   = load ? init_clamp :
                     !adjust ? trim_code :
                     up ? trim_code + 5'd1 : trim_code - 5'd1;
        trim_nxt   = (26'd1 << code_nxt) - 26'd1;
        lcnt_nxt   = (state_nxt != TRACK || adjust) ? 3'd0 :
                     (tick_trk && lcnt != 3'd4) ? lcnt + 3'd1 : lcnt;
    end

    always_ff @(posedge hiclock or posedge ireset)
        if (ireset) begin
            trim_code <= '0;
            trim      <= '0;
            lcnt      <= '0;
            lock      <= 1'b0;
        end else begin
            trim_code <= code_nxt;
            trim      <= trim_nxt;
            lcnt      <= lcnt_nxt;
            lock      <= lcnt_nxt == 3'd4;
        end
endmodule

// File: tb/tb_dco_trim_ctrl.sv
// tb_dco_trim_ctrl: scoreboard bench; osc_ref rises every m hiclock cycles so each tick measures m.
module tb_dco_trim_ctrl;
    logic        hiclock = 1'b0;
    logic        ireset = 1'b1;
    logic        enable = 1'b0;
    logic        osc_ref = 1'b0;
    logic [7:0]  target = '0;
    logic [4:0]  init_code = '0;
    logic [25:0] trim;
    logic [4:0]  trim_code;
    logic        lock;

    typedef struct {logic [4:0] code; logic lock;} exp_t;
    exp_t sb[$];

    int n_run = 0, n_fail = 0, since = 0;
    int m_st = 0, m_lc = 0;
    logic [4:0] m_code = '0;
    logic m_lock = 1'b0;

    always #5 hiclock = ~hiclock;

    dco_trim_ctrl dut (
        .hiclock(hiclock), .ireset(ireset), .enable(enable), .osc_ref(osc_ref),
        .target(target), .init_code(init_code), .trim(trim), .trim_code(trim_code), .lock(lock)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] therm(input logic [4:0] c);
        logic [25:0] t;
        for (int i = 0; i < 26; i++) t[i] = i < int'(c);
        return t;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge hiclock);
        since += n;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_code"}, trim_code, e.code);
        check({tag, "_trim"}, trim, therm(e.code));
        check({tag, "_lock"}, lock, e.lock);
    endtask

    task automatic model_reset();
        m_st = 0; m_lc = 0; m_code = '0; m_lock = 1'b0;
    endtask

    task automatic set_en(input logic e, input string tag);
        enable = e;
        if (e && m_st == 0) begin
            m_st = 1;
            m_code = init_code > 26 ? 5'd26 : init_code;
        end
        if (!e) m_st = 0;
        m_lc = 0; m_lock = 1'b0;
        sb.push_back('{m_code, m_lock});
        cyc(2);
        pop_check(tag);
    endtask

    task automatic step(input int m, input bit drop);
        bit up, dn;
`ifdef DCO_TRIM_DEADBAND_EN
        up = m > int'(target) + 1;
        dn = m + 1 < int'(target);
`else
        up = m > int'(target);
        dn = m < int'(target);
`endif
        if (drop || !enable) begin
            m_st = 0; m_lc = 0; m_lock = 1'b0;
        end else if (m_st == 1) begin
            m_st = 2;
        end else if (m_st == 2) begin
            if ((up && m_code != 26) || (dn && m_code != 0)) begin
                m_code = up ? m_code + 5'd1 : m_code - 5'd1;
                m_lc = 0; m_lock = 1'b0;
            end else begin
                m_lc = m_lc < 4 ? m_lc + 1 : 4;
                m_lock = m_lc == 4;
            end
        end
    endtask

    // Rising edge of osc_ref lands m cycles after the previous one; tick is live at n2, result at n3.
    task automatic tick(input int m, input bit drop, input string tag);
        logic [4:0] old;
        repeat (m / 2 - since) @(negedge hiclock);
        osc_ref = 1'b0;
        repeat (m - m / 2) @(negedge hiclock);
        osc_ref = 1'b1;
        since = 0;
        old = m_code;
        step(m, drop);
        sb.push_back('{m_code, m_lock});
        cyc(2);
        check({tag, "_hold_before"}, trim_code, old);
        if (drop) enable = 1'b0;
        cyc(1);
        pop_check(tag);
    endtask

    initial begin
        cyc(3);
        check("rst_code", trim_code, 0);
        check("rst_trim", trim, 0);
        check("rst_lock", lock, 0);
        ireset = 1'b0;
        since = 0;

        target = 8'd40; init_code = 5'd5;
        set_en(1'b1, "arm5");
        tick(44, 0, "arm_tick");
        tick(44, 0, "adj6");
        tick(44, 0, "adj7");
        check("adj7_trim_7f", trim, 32'h7F);

        target = 8'd44;
        for (int i = 0; i < 4; i++) tick(44, 0, "lock_eq");
        check("lock_set", lock, 1);
        tick(46, 0, "lock_break");
        target = 8'd46;
        for (int i = 0; i < 4; i++) tick(46, 0, "relock");
        target = 8'd47;
        cyc(2);
        check("tgt_chg_lock", lock, m_lock);
        tick(47, 0, "tgt_new_eq");
        tick(48, 0, "plus_one");

        tick(48, 1, "drop_en");
        cyc(3);
        check("idle_hold_code", trim_code, m_code);
        check("idle_lock", lock, 0);

        init_code = 5'd9; target = 8'd40;
        set_en(1'b1, "arm9");
        tick(40, 0, "track9");
        #1 ireset = 1'b1;
        #1;
        check("async_rst_code", trim_code, 0);
        check("async_rst_trim", trim, 0);
        check("async_rst_lock", lock, 0);
        model_reset();
        @(negedge hiclock);
        ireset = 1'b0;
        enable = 1'b0;
        since = 0;

        init_code = 5'd31; target = 8'd20;
        set_en(1'b1, "arm_clamp");
        for (int i = 0; i < 5; i++) tick(30, 0, "sat_hi");
        check("sat_trim_full", trim, 32'h3FFFFFF);
        check("sat_lock", lock, 1);

        set_en(1'b0, "off");
        init_code = 5'd0; target = 8'd60;
        set_en(1'b1, "arm0");
        for (int i = 0; i < 3; i++) tick(20, 0, "sat_lo");

        osc_ref = 1'b1;
        ireset = 1'b1;
        enable = 1'b0;
        cyc(2);
        ireset = 1'b0;
        model_reset();
        since = 0;
        init_code = 5'd10; target = 8'd20;
        set_en(1'b1, "arm10");
        cyc(8);
        tick(30, 0, "no_spurious");
        check("no_spurious_code10", trim_code, 10);
        tick(30, 0, "post_spurious");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
